// File: rtl/div_sequencer.sv
// Purpose: multi-cycle signed divider (restoring, one step per clock) returning {quotient, remainder}.
// Latency: WIDTH+1 cycles accept-to-done for a normal divide, 1 cycle for divide-by-zero.
// Backpressure: none; start is sampled only while idle and is never queued while busy.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 clear_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ITER  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]           state_q,  state_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [WIDTH:0]       acc_q,    acc_d;     // partial remainder A (W+1 bits)
    logic [WIDTH-1:0]     quo_q,    quo_d;     // Q; holds the raw dividend on divide-by-zero
    logic [WIDTH-1:0]     dvs_q,    dvs_d;     // D = |b|
    logic                 sign_q_q, sign_q_d;  // quotient negative
    logic                 sign_r_q, sign_r_d;  // remainder negative (dividend sign)
    logic                 dz_q,     dz_d;
    logic                 dzo_q,    dzo_d;     // div_by_zero output register
    logic [2*WIDTH-1:0]   res_q,    res_d;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH+1:0]     shifted;
    logic [WIDTH+1:0]     trial;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    // Operand magnitudes and the restoring-division trial subtraction.
    always_comb begin
        a_mag   = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
        b_mag   = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
        shifted = {acc_q, quo_q[WIDTH-1]};
        trial   = shifted - {2'b00, dvs_q};
        quo_fix = sign_q_q ? (~quo_q + WIDTH'(1)) : quo_q;
        rem_fix = sign_r_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    end

    // Next-state logic for the FSM and datapath registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        sign_q_d = sign_q_q;
        sign_r_d = sign_r_q;
        dz_d     = dz_q;
        dzo_d    = dzo_q;
        res_d    = res_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sign_q_d = a[WIDTH-1] ^ b[WIDTH-1];
                    sign_r_d = a[WIDTH-1];
                    dvs_d    = b_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
                    if (b == '0) begin
                        // Keep the raw dividend so it can be returned as the remainder.
                        quo_d   = a;
                        dz_d    = 1'b1;
                        state_d = S_FIXUP;
                    end else begin
                        quo_d   = a_mag;
                        dz_d    = 1'b0;
                        state_d = S_ITER;
                    end
                end
            end
            S_ITER: begin
                if (!trial[WIDTH+1]) begin
                    acc_d = trial[WIDTH:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = shifted[WIDTH:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                dzo_d   = dz_q;
                res_d   = dz_q ? {{WIDTH{1'b1}}, quo_q} : {quo_fix, rem_fix};
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            dz_q     <= 1'b0;
            dzo_q    <= 1'b0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
            dz_q     <= dz_d;
            dzo_q    <= dzo_d;
            res_q    <= res_d;
        end
    end

    // Outputs decode directly from registered state; no input-to-output path.
    always_comb begin
        busy        = (state_q == S_ITER) || (state_q == S_FIXUP);
        done        = (state_q == S_DONE);
        div_by_zero = dzo_q;
        result      = res_q;
    end

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;

    logic        clock;
    logic        clear_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;

    div_sequencer #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .result      (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Issue one divide and check latency, busy span, pulse width and the result.
    task automatic run_div(input logic [31:0] ai, input logic [31:0] bi,
                           input logic [31:0] eq, input logic [31:0] er,
                           input logic edz, input int elat, input string tag);
        int lat;
        int busy_cnt;
        logic got;
        @(negedge clock);
        a = ai; b = bi; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        a = $urandom; b = $urandom;       // operands may change after accept
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clock); #1;
            lat++;
            if (done) got = 1'b1;
            else if (busy) busy_cnt++;
        end
        if (!got) begin
            check({tag, " timeout"}, 64'd0, 64'd1);
        end else begin
            check({tag, " latency"}, 64'(lat), 64'(elat));
            check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(elat));
            check({tag, " busy_at_done"}, {63'd0, busy}, 64'd0);
            check({tag, " result"}, result, {eq, er});
            check({tag, " div_by_zero"}, {63'd0, div_by_zero}, {63'd0, edz});
            @(posedge clock); #1;
            check({tag, " done_pulse"}, {63'd0, done}, 64'd0);
            check({tag, " result_hold"}, result, {eq, er});
        end
    endtask

    initial begin
        vecs[0] = '{32'd100,      32'd7,          32'd14,         32'd2,          1'b0, 33};
        vecs[1] = '{-32'sd100,    32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 33};
        vecs[2] = '{32'd100,      -32'sd7,        32'hFFFFFFF2,   32'd2,          1'b0, 33};
        vecs[3] = '{32'h80000000, 32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 33};
        vecs[4] = '{32'd55,       32'd0,          32'hFFFFFFFF,   32'd55,         1'b1, 1};
        vecs[5] = '{-32'sd100,    -32'sd7,        32'd14,         32'hFFFFFFFE,   1'b0, 33};
        vecs[6] = '{32'd7,        32'd100,        32'd0,          32'd7,          1'b0, 33};
        vecs[7] = '{32'h7FFFFFFF, 32'd1,          32'h7FFFFFFF,   32'd0,          1'b0, 33};
        vecs[8] = '{32'hFFFFFFFF, 32'd0,          32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 1};
        vecs[9] = '{32'h80000000, 32'h80000000,   32'd1,          32'd0,          1'b0, 33};

        clear_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset dz", {63'd0, div_by_zero}, 64'd0);
        check("reset result", result, 64'd0);
        @(negedge clock);
        clear_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz,
                    vecs[i].lat, $sformatf("vec%0d", i));
        end

        // Second start while busy must be ignored.
        begin
            int cyc;
            int done_cnt;
            int first_done;
            logic [63:0] res_at_done;
            @(negedge clock);
            a = 32'd9; b = 32'd2; start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
            cyc = 0; done_cnt = 0; first_done = -1; res_at_done = '0;
            for (int k = 0; k < 70; k++) begin
                if (cyc == 9) begin
                    @(negedge clock);
                    a = 32'd50; b = 32'd5; start = 1'b1;
                end
                @(posedge clock); #1;
                start = 1'b0;
                cyc++;
                if (done) begin
                    done_cnt++;
                    if (first_done < 0) begin
                        first_done = cyc;
                        res_at_done = result;
                    end
                end
            end
            check("ignore done_count", 64'(done_cnt), 64'd1);
            check("ignore latency", 64'(first_done), 64'd33);
            check("ignore result", res_at_done, {32'd4, 32'd1});
        end

        // Reset in the middle of a divide discards it.
        begin
            int done_cnt;
            @(negedge clock);
            a = 32'd100; b = 32'd7; start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
            repeat (5) @(posedge clock);
            @(negedge clock);
            clear_n = 1'b0;
            #1;
            check("midreset busy", {63'd0, busy}, 64'd0);
            check("midreset done", {63'd0, done}, 64'd0);
            check("midreset dz", {63'd0, div_by_zero}, 64'd0);
            check("midreset result", result, 64'd0);
            repeat (2) @(posedge clock);
            @(negedge clock);
            clear_n = 1'b1;
            done_cnt = 0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clock); #1;
                if (done || busy) done_cnt++;
            end
            check("midreset no_done", 64'(done_cnt), 64'd0);
        end

        run_div(32'd9, 32'd2, 32'd4, 32'd1, 1'b0, 33, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
